fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 33 +++
 rtl/fetch_unit_npc.sv | 45 ++++
 rtl/fetch_unit.sv | 132 +++++++++++++
 tb/tb_fetch_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
// Purpose : Definitions shared by the instruction fetch unit and its next-PC
//           logic: next-PC select codes, fetch FSM state codes, the wait
//           counter width and a word-alignment helper.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

    // Next-PC select codes driven on npc_op. Code 2'd3 is reserved and
    // behaves like NPC_PC4.
    typedef enum logic [1:0] {
        NPC_PC4  = 2'd0,
        NPC_BR   = 2'd1,
        NPC_JALR = 2'd2
    } npc_op_e;

    // Fetch FSM states.
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    // Wide enough for the largest supported TIMEOUT_CYC (15).
    localparam int unsigned WAIT_CNT_W = 4;

    // Force an address onto a 4-byte boundary.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage : fetch_unit_pkg

// File: rtl/fetch_unit_npc.sv
// -----------------------------------------------------------------------------
// fetch_unit_npc
// Purpose : Purely combinational next-PC calculation for the held instruction.
//           The result is left unaligned so the caller can flag a misaligned
//           target before forcing word alignment.
// Ports   :
//   pc_i        [31:0]  address of the held instruction
//   npc_op_i    [1:0]   next-PC select (PC4 / BR / JALR, 3 = reserved)
//   br_taken_i          branch condition, used only for BR
//   sext_ext_i  [31:0]  sign-extended branch offset
//   alu_c_i     [31:0]  JALR target from the ALU
//   npc_o       [31:0]  next PC (JALR bit 0 already cleared, bit 1 untouched)
//   pc4_o       [31:0]  pc + 4
// -----------------------------------------------------------------------------
module fetch_unit_npc
    import fetch_unit_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [1:0]  npc_op_i,
    input  logic        br_taken_i,
    input  logic [31:0] sext_ext_i,
    input  logic [31:0] alu_c_i,
    output logic [31:0] npc_o,
    output logic [31:0] pc4_o
);

    // All additions wrap silently modulo 2^32.
    logic [31:0] br_target;

    assign pc4_o     = pc_i + 32'd4;
    assign br_target = pc_i + sext_ext_i;

    always_comb begin
        // NOTE: assigning a default before the case guarantees every path
        // drives npc_o, so no latch can be inferred.
        npc_o = pc4_o;
        case (npc_op_i)
            NPC_PC4:  npc_o = pc4_o;
            NPC_BR:   npc_o = br_taken_i ? br_target : pc4_o;
            NPC_JALR: npc_o = {alu_c_i[31:1], 1'b0};
            default:  npc_o = pc4_o;
        endcase
    end

endmodule : fetch_unit_npc

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Purpose : Single-outstanding-request instruction fetch unit. Issues one
//           fetch per instruction, waits (with timeout/re-request) for the
//           IROM response, holds the instruction until decode accepts it and
//           then advances the PC.
// Ports   :
//   clk                 clock, all state on rising edge
//   rst_n               asynchronous reset, ACTIVE-HIGH despite the name
//   npc_op      [1:0]   next-PC select for the held instruction
//   br_taken            branch condition for the held instruction
//   sext_ext    [31:0]  sign-extended immediate of the held instruction
//   alu_c       [31:0]  ALU result (JALR target) of the held instruction
//   id_ready            decode accepts the held instruction this cycle
//   irom_req            one-cycle fetch request strobe
//   irom_addr   [31:0]  fetch address (= pc)
//   irom_rvalid         irom_rdata valid this cycle
//   irom_rdata  [31:0]  fetched instruction word
//   irom_inst   [31:0]  held instruction
//   inst_valid          irom_inst valid, awaiting acceptance
//   pc          [31:0]  address of the held / in-flight instruction
//   npc_pc4     [31:0]  pc + 4 for link write-back
//   misalign            pulse: last computed next PC had bits [1:0] nonzero
//   irom_timeout        pulse: IROM did not answer within TIMEOUT_CYC cycles
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  npc_op,
    input  logic        br_taken,
    input  logic [31:0] sext_ext,
    input  logic [31:0] alu_c,
    input  logic        id_ready,
    output logic        irom_req,
    output logic [31:0] irom_addr,
    input  logic        irom_rvalid,
    input  logic [31:0] irom_rdata,
    output logic [31:0] irom_inst,
    output logic        inst_valid,
    output logic [31:0] pc,
    output logic [31:0] npc_pc4,
    output logic        misalign,
    output logic        irom_timeout
);

    // Last WAIT count before the timeout fires, so WAIT lasts exactly
    // TIMEOUT_CYC cycles when the IROM stays silent.
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(TIMEOUT_CYC - 1);

    state_e                  state_q;
    logic [31:0]             pc_q;
    logic [31:0]             inst_q;
    logic [WAIT_CNT_W-1:0]   wait_cnt_q;
    logic                    misalign_q;
    logic                    timeout_q;
    logic [31:0]             npc_d;
    logic [31:0]             pc4_d;

    fetch_unit_npc u_npc (
        .pc_i       (pc_q),
        .npc_op_i   (npc_op),
        .br_taken_i (br_taken),
        .sext_ext_i (sext_ext),
        .alu_c_i    (alu_c),
        .npc_o      (npc_d),
        .pc4_o      (pc4_d)
    );

    // rst_n is active-high here. Next-PC operands are only looked at on the
    // accept edge, so they may change freely while the instruction is held.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            inst_q     <= 32'h0;
            wait_cnt_q <= '0;
            misalign_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register sees the pre-edge values of the others.
            misalign_q <= 1'b0;
            timeout_q  <= 1'b0;
            case (state_q)
                S_REQ: begin
                    // A response arriving here belongs to an abandoned
                    // request and is dropped.
                    wait_cnt_q <= '0;
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    if (irom_rvalid) begin
                        inst_q     <= irom_rdata;
                        wait_cnt_q <= '0;
                        state_q    <= S_HOLD;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        wait_cnt_q <= '0;
                        timeout_q  <= 1'b1;
                        state_q    <= S_REQ;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (id_ready) begin
                        pc_q       <= align_word(npc_d);
                        misalign_q <= |npc_d[1:0];
                        state_q    <= S_REQ;
                    end
                end
                default: state_q <= S_REQ;
            endcase
        end
    end

    // Moore decode of the state, additionally gated by reset so that nothing
    // is requested or presented while reset is held.
    assign irom_req     = (state_q == S_REQ)  && !rst_n;
    assign inst_valid   = (state_q == S_HOLD) && !rst_n;
    assign irom_addr    = pc_q;
    assign pc           = pc_q;
    assign irom_inst    = inst_q;
    assign npc_pc4      = pc4_d;
    assign misalign     = misalign_q;
    assign irom_timeout = timeout_q;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Purpose : Directed self-checking bench for fetch_unit. Inputs change 1 time
//           unit after each rising edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  npc_op = 2'd0;
    logic        br_taken = 1'b0;
    logic [31:0] sext_ext = 32'h0;
    logic [31:0] alu_c = 32'h0;
    logic        id_ready = 1'b0;
    logic        irom_req;
    logic [31:0] irom_addr;
    logic        irom_rvalid = 1'b0;
    logic [31:0] irom_rdata = 32'h0;
    logic [31:0] irom_inst;
    logic        inst_valid;
    logic [31:0] pc;
    logic [31:0] npc_pc4;
    logic        misalign;
    logic        irom_timeout;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .npc_op       (npc_op),
        .br_taken     (br_taken),
        .sext_ext     (sext_ext),
        .alu_c        (alu_c),
        .id_ready     (id_ready),
        .irom_req     (irom_req),
        .irom_addr    (irom_addr),
        .irom_rvalid  (irom_rvalid),
        .irom_rdata   (irom_rdata),
        .irom_inst    (irom_inst),
        .inst_valid   (inst_valid),
        .pc           (pc),
        .npc_pc4      (npc_pc4),
        .misalign     (misalign),
        .irom_timeout (irom_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expects the DUT in S_REQ at exp_addr; answers with IROM latency 2 and
    // leaves the DUT holding the instruction.
    task automatic fetch_inst(input string tag, input logic [31:0] exp_addr,
                              input logic [31:0] data);
        n_cmp++; if (irom_req !== 1'b1) begin n_bad++; $display("FAIL %s_req: got %0b want 1", tag, irom_req); end
        n_cmp++; if (irom_addr !== exp_addr) begin n_bad++; $display("FAIL %s_addr: got %h want %h", tag, irom_addr, exp_addr); end
        tick();
        n_cmp++; if ({irom_req, inst_valid} !== 2'b00) begin n_bad++; $display("FAIL %s_wait: req/valid got %b want 00", tag, {irom_req, inst_valid}); end
        irom_rvalid = 1'b0;
        tick();
        irom_rvalid = 1'b1;
        irom_rdata  = data;
        tick();
        irom_rvalid = 1'b0;
        irom_rdata  = 32'hDEAD_BEEF;
        n_cmp++; if (inst_valid !== 1'b1) begin n_bad++; $display("FAIL %s_valid: got %0b want 1", tag, inst_valid); end
        n_cmp++; if (irom_inst !== data) begin n_bad++; $display("FAIL %s_inst: got %h want %h", tag, irom_inst, data); end
        n_cmp++; if (pc !== exp_addr) begin n_bad++; $display("FAIL %s_pc: got %h want %h", tag, pc, exp_addr); end
    endtask

    // Accepts the held instruction and checks the following S_REQ cycle.
    task automatic accept(input string tag, input logic [1:0] op, input logic taken,
                          input logic [31:0] sext, input logic [31:0] alu,
                          input logic [31:0] exp_addr, input logic exp_mis);
        npc_op   = op;
        br_taken = taken;
        sext_ext = sext;
        alu_c    = alu;
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        npc_op   = 2'd3;
        alu_c    = 32'h5555_5555;
        sext_ext = 32'h0000_0404;
        br_taken = 1'b1;
        n_cmp++; if (irom_req !== 1'b1) begin n_bad++; $display("FAIL %s_req: got %0b want 1", tag, irom_req); end
        n_cmp++; if (irom_addr !== exp_addr) begin n_bad++; $display("FAIL %s_npc: got %h want %h", tag, irom_addr, exp_addr); end
        n_cmp++; if (misalign !== exp_mis) begin n_bad++; $display("FAIL %s_misalign: got %0b want %0b", tag, misalign, exp_mis); end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        tick();
        tick();
        n_cmp++; if ({irom_req, inst_valid} !== 2'b00) begin n_bad++; $display("FAIL rst_outputs: req/valid got %b want 00", {irom_req, inst_valid}); end
        n_cmp++; if (pc !== 32'h0) begin n_bad++; $display("FAIL rst_pc: got %h want 0", pc); end
        n_cmp++; if (irom_inst !== 32'h0) begin n_bad++; $display("FAIL rst_inst: got %h want 0", irom_inst); end
        n_cmp++; if ({misalign, irom_timeout} !== 2'b00) begin n_bad++; $display("FAIL rst_pulses: got %b want 00", {misalign, irom_timeout}); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (irom_req !== 1'b1 || irom_addr !== 32'h0) begin n_bad++; $display("FAIL rst_release: req=%0b addr=%h want 1/0", irom_req, irom_addr); end
    endtask

    task automatic test_first_fetch();
        fetch_inst("first", 32'h0, 32'h0050_0093);
        n_cmp++; if (npc_pc4 !== 32'h4) begin n_bad++; $display("FAIL first_pc4: got %h want 4", npc_pc4); end
        accept("first_acc", 2'd0, 1'b0, 32'h0, 32'h0, 32'h4, 1'b0);
    endtask

    task automatic test_branch();
        fetch_inst("jtgt", 32'h4, 32'h1111_0001);
        accept("jtgt_acc", 2'd2, 1'b0, 32'h0, 32'h0000_0100, 32'h100, 1'b0);
        fetch_inst("br", 32'h100, 32'h2222_0002);
        accept("br_taken", 2'd1, 1'b1, 32'hFFFF_FFF0, 32'h0, 32'h0F0, 1'b0);
        fetch_inst("brn", 32'h0F0, 32'h3333_0003);
        accept("br_not", 2'd1, 1'b0, 32'hFFFF_FFF0, 32'h0, 32'h0F4, 1'b0);
    endtask

    task automatic test_jalr();
        fetch_inst("jalr", 32'h0F4, 32'h4444_0004);
        accept("jalr_mis", 2'd2, 1'b0, 32'h0, 32'h0000_2003, 32'h2000, 1'b1);
        fetch_inst("jalr2", 32'h2000, 32'h5555_0005);
        n_cmp++; if (misalign !== 1'b0) begin n_bad++; $display("FAIL jalr_pulse_len: got %0b want 0", misalign); end
        accept("jalr_bit0", 2'd2, 1'b0, 32'h0, 32'h0000_2001, 32'h2000, 1'b0);
    endtask

    task automatic test_stall();
        fetch_inst("stall", 32'h2000, 32'h6666_0006);
        for (int i = 0; i < 5; i++) begin
            irom_rvalid = 1'b1;
            irom_rdata  = 32'h7777_0000 + 32'(i);
            npc_op      = 2'd2;
            alu_c       = 32'h0000_0800;
            tick();
            n_cmp++; if (inst_valid !== 1'b1 || irom_req !== 1'b0) begin n_bad++; $display("FAIL stall_ctl%0d: valid=%0b req=%0b want 1/0", i, inst_valid, irom_req); end
            n_cmp++; if (irom_inst !== 32'h6666_0006 || pc !== 32'h2000) begin n_bad++; $display("FAIL stall_hold%0d: inst=%h pc=%h want 66660006/2000", i, irom_inst, pc); end
        end
        irom_rvalid = 1'b0;
        accept("reserved_op", 2'd3, 1'b1, 32'h0000_0100, 32'h0000_0800, 32'h2004, 1'b0);
    endtask

    task automatic test_wrap();
        fetch_inst("wrap_pre", 32'h2004, 32'h8888_0008);
        accept("wrap_jump", 2'd2, 1'b0, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
        fetch_inst("wrap", 32'hFFFF_FFFC, 32'h9999_0009);
        n_cmp++; if (npc_pc4 !== 32'h0) begin n_bad++; $display("FAIL wrap_pc4: got %h want 0", npc_pc4); end
        accept("wrap_acc", 2'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_timeout();
        for (int i = 1; i <= 15; i++) begin
            tick();
            n_cmp++; if ({irom_req, irom_timeout} !== 2'b00) begin n_bad++; $display("FAIL to_wait%0d: req/timeout got %b want 00", i, {irom_req, irom_timeout}); end
        end
        tick();
        n_cmp++; if (irom_timeout !== 1'b1) begin n_bad++; $display("FAIL to_pulse: got %0b want 1", irom_timeout); end
        n_cmp++; if (irom_req !== 1'b1 || irom_addr !== 32'h0) begin n_bad++; $display("FAIL to_rereq: req=%0b addr=%h want 1/0", irom_req, irom_addr); end
        // Late response during S_REQ must be dropped.
        irom_rvalid = 1'b1;
        irom_rdata  = 32'hBAD0_0001;
        tick();
        irom_rvalid = 1'b0;
        n_cmp++; if ({inst_valid, irom_timeout} !== 2'b00) begin n_bad++; $display("FAIL to_late: valid/timeout got %b want 00", {inst_valid, irom_timeout}); end
        irom_rvalid = 1'b1;
        irom_rdata  = 32'hAAAA_000A;
        tick();
        irom_rvalid = 1'b0;
        n_cmp++; if (inst_valid !== 1'b1 || irom_inst !== 32'hAAAA_000A) begin n_bad++; $display("FAIL to_recover: valid=%0b inst=%h want 1/aaaa000a", inst_valid, irom_inst); end
        accept("to_acc", 2'd0, 1'b0, 32'h0, 32'h0, 32'h4, 1'b0);
    endtask

    task automatic test_reset_mid_wait();
        fetch_inst("rw_pre", 32'h4, 32'hBBBB_000B);
        accept("rw_jump", 2'd2, 1'b0, 32'h0, 32'h0000_0040, 32'h40, 1'b0);
        tick();
        rst_n = 1'b1;
        #1;
        n_cmp++; if (pc !== 32'h0) begin n_bad++; $display("FAIL rw_async_pc: got %h want 0", pc); end
        n_cmp++; if ({irom_req, inst_valid} !== 2'b00) begin n_bad++; $display("FAIL rw_gated: req/valid got %b want 00", {irom_req, inst_valid}); end
        irom_rvalid = 1'b1;
        irom_rdata  = 32'hBAD0_0002;
        tick();
        rst_n = 1'b0;
        #1;
        n_cmp++; if (irom_req !== 1'b1 || irom_addr !== 32'h0) begin n_bad++; $display("FAIL rw_refetch: req=%0b addr=%h want 1/0", irom_req, irom_addr); end
        tick();
        irom_rvalid = 1'b0;
        tick();
        n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL rw_drop: valid got %0b want 0", inst_valid); end
        irom_rvalid = 1'b1;
        irom_rdata  = 32'hCCCC_000C;
        tick();
        irom_rvalid = 1'b0;
        n_cmp++; if (inst_valid !== 1'b1 || irom_inst !== 32'hCCCC_000C || pc !== 32'h0) begin n_bad++; $display("FAIL rw_final: valid=%0b inst=%h pc=%h", inst_valid, irom_inst, pc); end
    endtask

    initial begin
        #1;
        test_reset();
        test_first_fetch();
        test_branch();
        test_jalr();
        test_stall();
        test_wrap();
        test_timeout();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_fetch_unit
